vga_timing_ctrl: RTL
====================

// Module: vga_timing_ctrl
// PURPOSE
//  Raster timing generator and pixel output stage for the VGA path; runs on the pixel clock.
//  Produces h_addr/v_addr to address the framebuffer. Accepts the framebuffer's 12-bit RGB
//  read data, aligns sync/blank to the framebuffer read latency and drives the VGA pins.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line;  H_FP 16 front porch;  H_SYNC 96 sync width;  H_BP 48 back porch
//  V_ACTIVE 480 visible lines/frame;  V_FP 10;  V_SYNC 2;  V_BP 33
//  FB_LAT   1   framebuffer read latency in clocks, 0..3 (0 = async-read model, 1 = block RAM)
// PORTS
//  clock       in   1   pixel clock (25 MHz for the defaults); the block's only clock
//  reset       in   1   asynchronous, active-low reset
//  h_addr      out  10  visible column 0..H_ACTIVE-1; 0 outside the active region
//  v_addr      out  10  visible row 0..V_ACTIVE-1; 0 outside the active region
//  fb_data     in   12  {r[3:0],g[3:0],b[3:0]} from the framebuffer, FB_LAT clocks after the address
//  vga_r/g/b   out  4   pixel colour, forced to 0 while blanked
//  vga_hs      out  1   horizontal sync, active-low
//  vga_vs      out  1   vertical sync, active-low
//  vga_de      out  1   display enable: the pixel on vga_r/g/b is visible
//  frame_start out  1   one-clock pulse aligned with pixel (0,0) on vga_de
// BEHAVIOUR
//  - Counters: hc 0..HT-1 (HT=H_ACTIVE+H_FP+H_SYNC+H_BP=800), vc 0..VT-1 (VT=525).
//    hc wraps HT-1->0 and vc increments on that wrap; vc wraps VT-1->0 when hc also wraps.
//  - Region map, counter 0 = first visible: active hc<H_ACTIVE; hsync region
//    H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751). V uses the same layout (sync = lines 490..491).
//  - h_addr/v_addr: combinational from the registered counters, so the address is valid in the
//    cycle it addresses. Zero outside the active region so the framebuffer never sees an
//    out-of-range column.
//  - Alignment: de/hs/vs/frame_start are computed from the counters, pass through an FB_LAT-deep
//    shift register, then through one output register. Total pin latency from counter state is
//    FB_LAT+1 clocks for every output. RGB is registered at the same output stage, and
//    vga_r/g/b = de_aligned ? fb_data : 0.
//  - Reset (async assert, sync release): hc=vc=0; delay stages cleared to de=0, hs=vs=1,
//    frame_start=0; outputs vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_de=0, frame_start=0.
//    The first clock after release addresses (0,0); frame_start pulses FB_LAT+1 clocks later.
//  - Reset mid-frame: the frame is abandoned immediately, and the sync pins go inactive
//    asynchronously. No partial sync pulse survives reset.
//  - The parameter sums must fit 10 bits (HT, VT <= 1024); elaborate-time $error otherwise.
// CONFIGURATION
//  VGA_VBLANK_IRQ_EN defined:
//    ports irq (out 1) and irq_clr (in 1) added.
//    irq is set sticky on the first clock of vc==V_ACTIVE, hc==0 (vblank entry, unaligned timing).
//    irq is cleared by irq_clr==1; a set and a clear in the same clock leave irq=1 (set wins).
//    irq resets to 0.
//  VGA_VBLANK_IRQ_EN undefined: neither port exists and no interrupt logic is generated.
// STRUCTURE
//  Package vga_pkg: default timing localparams (640x480@60), typedef rgb12_t {r,g,b 4b each},
//  typedef struct vga_ctl_t {de,hs,vs,fs}.
//  One sub-module, vga_delay_line #(W,DEPTH): W-bit shift register with DEPTH 0 acting as a wire.
//  Used for vga_ctl_t alignment.
// TESTING
//  1 Reset held 5 clks, release -> vga_hs=vga_vs=1, vga_de=0, rgb=0; h_addr=0,v_addr=0 on the first clock.
//  2 Free-run 1 line, FB_LAT=1 -> vga_de high exactly 640 clks starting 2 clks after hc=0;
//    vga_hs low exactly 96 clks starting at the clock 656+2 after line start.
//  3 Free-run 2 frames -> 800*525=420000 clks between frame_start pulses;
//    vga_vs low for exactly 2*800=1600 clks per frame.
//  4 fb_data driven as {h_addr[3:0],v_addr[3:0],4'hA} through a model with FB_LAT=1 ->
//    pin pixel at (5,7) reads 12'h57A; during blanking, drive fb_data=12'hFFF -> rgb stays 0.
//  5 Reset asserted at hc=700,vc=490 (inside vsync) -> vga_vs=1 and vga_hs=1 within the same clock;
//    after release the timing restarts from (0,0).
//  6 VGA_VBLANK_IRQ_EN: at hc=0,vc=480 -> irq=1 next clk and stays set; irq_clr=1 for one clk -> irq=0.
//    irq_clr asserted on the set clock -> irq stays 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster path.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int FB_LAT_DEF   = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // hs/vs carry the pin level (active-low), de/fs are active-high
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } vga_ctl_t;

  // Blanked, no sync asserted, no frame marker
  localparam vga_ctl_t CTL_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// W-bit shift register of DEPTH stages; DEPTH 0 degenerates to a plain wire.
// Stages clear to RESET_VAL so a fresh reset never leaks stale control bits.
module vga_delay_line #(
  parameter int            W         = 1,
  parameter int            DEPTH     = 1,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = &{1'b0, clock, reset};
    assign o_q      = i_d;
  end else begin : g_shift
    logic [W-1:0] r_stage [DEPTH];

    // Shift one stage per clock; stage 0 takes the fresh input
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator and pixel output stage (pixel clock domain).
// Counters address the framebuffer combinationally; control bits are delayed by
// FB_LAT to meet the returning pixel data, then everything is registered once.
// Optional feature macro: VGA_VBLANK_IRQ_EN adds irq/irq_clr (sticky vblank-entry flag).
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int FB_LAT   = FB_LAT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  input  logic [11:0] fb_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start
`ifdef VGA_VBLANK_IRQ_EN
  ,
  input  logic        irq_clr,
  output logic        irq
`endif
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HT > 1024 || VT > 1024 || FB_LAT < 0 || FB_LAT > 3) begin : g_param_check
    $error("vga_timing_ctrl: HT/VT must be <= 1024 and FB_LAT in 0..3");
  end

  // Region bounds are 11 bits wide so a full 1024 total never wraps to 0
  localparam logic [9:0]  HT_LAST  = 10'(HT - 1);
  localparam logic [9:0]  VT_LAST  = 10'(VT - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       w_active;
  logic       w_h_sync;
  logic       w_v_sync;
  vga_ctl_t   w_ctl;
  vga_ctl_t   w_ctl_aligned;
  vga_ctl_t   r_ctl;
  rgb12_t     r_rgb;

  // Raster position: hc runs along the line, vc steps on each line wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_hc == HT_LAST) begin
      r_hc <= '0;
      r_vc <= (r_vc == VT_LAST) ? '0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  assign w_active = ({1'b0, r_hc} < H_ACT) && ({1'b0, r_vc} < V_ACT);
  assign w_h_sync = ({1'b0, r_hc} >= HS_START) && ({1'b0, r_hc} < HS_END);
  assign w_v_sync = ({1'b0, r_vc} >= VS_START) && ({1'b0, r_vc} < VS_END);

  assign h_addr = w_active ? r_hc : '0;
  assign v_addr = w_active ? r_vc : '0;

  // Decode unaligned control bits for the position currently being addressed
  always_comb begin
    w_ctl    = CTL_IDLE;
    w_ctl.de = w_active;
    w_ctl.hs = ~w_h_sync;
    w_ctl.vs = ~w_v_sync;
    w_ctl.fs = (r_hc == '0) && (r_vc == '0);
  end

  vga_delay_line #(
    .W         ($bits(vga_ctl_t)),
    .DEPTH     (FB_LAT),
    .RESET_VAL (CTL_IDLE)
  ) u_ctl_delay (
    .clock (clock),
    .reset (reset),
    .i_d   (w_ctl),
    .o_q   (w_ctl_aligned)
  );

  // Output stage: control and returning pixel land on the pins together
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ctl <= CTL_IDLE;
      r_rgb <= '0;
    end else begin
      r_ctl <= w_ctl_aligned;
      r_rgb <= w_ctl_aligned.de ? rgb12_t'(fb_data) : '0;
    end
  end

  assign vga_r       = r_rgb.r;
  assign vga_g       = r_rgb.g;
  assign vga_b       = r_rgb.b;
  assign vga_de      = r_ctl.de;
  assign vga_hs      = r_ctl.hs;
  assign vga_vs      = r_ctl.vs;
  assign frame_start = r_ctl.fs;

`ifdef VGA_VBLANK_IRQ_EN
  logic w_vblank_entry;
  logic r_irq;

  assign w_vblank_entry = (r_hc == '0) && ({1'b0, r_vc} == V_ACT);

  // Sticky vblank flag; a set in the same clock as a clear wins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= w_vblank_entry | (r_irq & ~irq_clr);
  end

  assign irq = r_irq;
`endif

endmodule
